// File: rtl/gf16_mul_feeder.sv
// Operand FIFO and share-refresh stage feeding the masked GF(16) multiplier.
// Build option: define GF16_FEEDER_REFRESH_EN to enable LFSR share refresh (default: shares pass through).
module gf16_mul_feeder #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned MUL_LAT    = 1,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       seed_load,
   input  logic [15:0] seed,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_a0,
   input  logic [3:0] in_a1,
   input  logic [3:0] in_b0,
   input  logic [3:0] in_b1,
   input  logic [3:0] in_c0,
   input  logic [3:0] in_c1,
   input  logic       issue_en,
   output logic [3:0] mul_a0,
   output logic [3:0] mul_a1,
   output logic [3:0] mul_b0,
   output logic [3:0] mul_b1,
   output logic [3:0] mul_c0,
   output logic [3:0] mul_c1,
   output logic       mul_issue,
   output logic       res_valid,
   output logic       busy
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SET_W = 24;

   // Operand set layout: {a0, a1, b0, b1, c0, c1}
   logic [SET_W-1:0] mem_q [FIFO_DEPTH];
   logic [SET_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [SET_W-1:0] mul_q, mul_d;
   logic             mul_issue_q, mul_issue_d;
   logic [MUL_LAT-1:0] vpipe_q, vpipe_d;

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [11:0]      r;
   logic [SET_W-1:0] head;
   logic [SET_W-1:0] mask;

   assign full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = !rst && !full;
   assign push     = in_valid && in_ready;
   assign pop      = issue_en && !empty;
   assign head     = mem_q[rd_ptr_q];
   assign mask     = {r[3:0], r[3:0], r[7:4], r[7:4], r[11:8], r[11:8]};

`ifdef GF16_FEEDER_REFRESH_EN
   logic [15:0] lfsr_q, lfsr_d, lfsr_adv;

   // Twelve unrolled Fibonacci steps, taken only when a set is issued
   always_comb begin
      lfsr_adv = lfsr_q;
      for (int unsigned i = 0; i < 12; i++) begin
         lfsr_adv = {lfsr_adv[14:0], lfsr_adv[15] ^ lfsr_adv[13] ^ lfsr_adv[12] ^ lfsr_adv[10]};
      end
   end

   always_comb begin
      lfsr_d = lfsr_q;
      if (seed_load) begin
         lfsr_d = (seed == 16'h0000) ? LFSR_SEED : seed;
      end else if (pop) begin
         lfsr_d = lfsr_adv;
      end
   end

   assign r = lfsr_q[11:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   logic unused_seed;
   assign unused_seed = ^{seed_load, seed};
   assign r = 12'h000;
`endif

   // FIFO storage, pointers and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {in_a0, in_a1, in_b0, in_b1, in_c0, in_c1};
         wr_ptr_d        = PTR_W'(wr_ptr_q + PTR_W'(1));
      end
      if (pop) begin
         rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
      end
      case ({push, pop})
         2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
         2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
         default: count_d = count_q;
      endcase
   end

   // Issue register holds its value while idle so the multiplier inputs never toggle
   always_comb begin
      mul_d       = mul_q;
      mul_issue_d = pop;
      if (pop) begin
         mul_d = head ^ mask;
      end
   end

   always_comb begin
      vpipe_d    = vpipe_q;
      vpipe_d[0] = mul_issue_q;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
         vpipe_d[i] = vpipe_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         mul_q       <= '0;
         mul_issue_q <= 1'b0;
         vpipe_q     <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mul_q       <= mul_d;
         mul_issue_q <= mul_issue_d;
         vpipe_q     <= vpipe_d;
      end
   end

   assign mul_a0    = mul_q[23:20];
   assign mul_a1    = mul_q[19:16];
   assign mul_b0    = mul_q[15:12];
   assign mul_b1    = mul_q[11:8];
   assign mul_c0    = mul_q[7:4];
   assign mul_c1    = mul_q[3:0];
   assign mul_issue = mul_issue_q;
   assign res_valid = vpipe_q[MUL_LAT-1];
   assign busy      = !empty || mul_issue_q || (|vpipe_q);

endmodule

// File: tb/tb_gf16_mul_feeder.sv
// Randomized and directed bench for gf16_mul_feeder against a queue-based reference model.
module tb_gf16_mul_feeder;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned LAT   = 1;
   localparam logic [15:0] SEED0 = 16'hACE1;
`ifdef GF16_FEEDER_REFRESH_EN
   localparam bit REFRESH = 1'b1;
`else
   localparam bit REFRESH = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        seed_load;
   logic [15:0] seed;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_a0, in_a1, in_b0, in_b1, in_c0, in_c1;
   logic        issue_en;
   logic [3:0]  mul_a0, mul_a1, mul_b0, mul_b1, mul_c0, mul_c1;
   logic        mul_issue;
   logic        res_valid;
   logic        busy;

   gf16_mul_feeder #(
      .FIFO_DEPTH(DEPTH),
      .MUL_LAT   (LAT),
      .LFSR_SEED (SEED0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .seed_load(seed_load),
      .seed     (seed),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a0    (in_a0),
      .in_a1    (in_a1),
      .in_b0    (in_b0),
      .in_b1    (in_b1),
      .in_c0    (in_c0),
      .in_c1    (in_c1),
      .issue_en (issue_en),
      .mul_a0   (mul_a0),
      .mul_a1   (mul_a1),
      .mul_b0   (mul_b0),
      .mul_b1   (mul_b1),
      .mul_c0   (mul_c0),
      .mul_c1   (mul_c1),
      .mul_issue(mul_issue),
      .res_valid(res_valid),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [23:0] m_fifo[$];
   logic [23:0] m_mul;
   bit          m_issue;
   bit          m_pipe[LAT];
   logic [15:0] m_lfsr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Polynomial x^16+x^14+x^13+x^11+1 as a tap mask, advanced twelve times
   function automatic logic [15:0] lfsr12(input logic [15:0] s);
      for (int i = 0; i < 12; i++) s = {s[14:0], ^(s & 16'hB400)};
      return s;
   endfunction

   function automatic logic [11:0] unmask(input logic [23:0] x);
      return {x[23:20] ^ x[19:16], x[15:12] ^ x[11:8], x[7:4] ^ x[3:0]};
   endfunction

   function automatic logic [23:0] dut_mul();
      return {mul_a0, mul_a1, mul_b0, mul_b1, mul_c0, mul_c1};
   endfunction

   task automatic set_ops(input logic [23:0] s);
      {in_a0, in_a1, in_b0, in_b1, in_c0, in_c1} = s;
   endtask

   task automatic model_update();
      bit          old_issue;
      bit          do_push;
      bit          do_pop;
      logic [23:0] incoming;
      logic [23:0] hd;
      logic [11:0] r;
      old_issue = m_issue;
      incoming  = {in_a0, in_a1, in_b0, in_b1, in_c0, in_c1};
      if (rst) begin
         m_fifo.delete();
         m_mul   = '0;
         m_issue = 1'b0;
         for (int i = 0; i < LAT; i++) m_pipe[i] = 1'b0;
         m_lfsr  = SEED0;
      end else begin
         do_push = in_valid && (m_fifo.size() < DEPTH);
         do_pop  = issue_en && (m_fifo.size() != 0);
         if (do_pop) begin
            hd      = m_fifo.pop_front();
            r       = REFRESH ? m_lfsr[11:0] : 12'h000;
            m_mul   = hd ^ {r[3:0], r[3:0], r[7:4], r[7:4], r[11:8], r[11:8]};
            m_issue = 1'b1;
         end else begin
            m_issue = 1'b0;
         end
         if (do_push) m_fifo.push_back(incoming);
         for (int i = LAT - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
         m_pipe[0] = old_issue;
         if (seed_load) m_lfsr = (seed == 16'h0000) ? SEED0 : seed;
         else if (do_pop) m_lfsr = lfsr12(m_lfsr);
      end
   endtask

   // One clock: check in_ready before the edge, advance the model, check outputs after it
   task automatic step();
      bit exp_busy;
      #1;
      check_eq("in_ready", 32'(in_ready), 32'(!rst && (m_fifo.size() < DEPTH)));
      model_update();
      @(posedge clk);
      #1;
      exp_busy = (m_fifo.size() != 0) || m_issue;
      for (int i = 0; i < LAT; i++) exp_busy = exp_busy || m_pipe[i];
      check_eq("mul_issue", 32'(mul_issue), 32'(m_issue));
      check_eq("mul_data", 32'(dut_mul()), 32'(m_mul));
      check_eq("res_valid", 32'(res_valid), 32'(m_pipe[LAT-1]));
      check_eq("busy", 32'(busy), 32'(exp_busy));
   endtask

   initial begin
      logic [23:0] s1, s2, s3;
      logic [23:0] snap;
      logic [15:0] lfsr_before;
      logic [3:0]  r_lo;

      rst = 1'b1; seed_load = 1'b0; seed = '0; in_valid = 1'b0; issue_en = 1'b0;
      set_ops(24'h0);
      m_mul = '0; m_issue = 1'b0; m_lfsr = SEED0;
      for (int i = 0; i < LAT; i++) m_pipe[i] = 1'b0;
      step(); step();
      check_eq("rst_issue", 32'(mul_issue), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;

      // Single set: issue two cycles after the push, result valid one latency later
      set_ops(24'h35_0F_99); in_valid = 1'b1; issue_en = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("t1_not_yet", 32'(mul_issue), 32'h0);
      step();
      check_eq("t1_issue", 32'(mul_issue), 32'h1);
      check_eq("t1_unmasked", 32'(unmask(dut_mul())), 32'h6F0);
      step();
      check_eq("t1_res_valid", 32'(res_valid), 32'h1);
      step();

      // Fill, back-pressure, then drain in order with contiguous issues
      issue_en = 1'b0;
      s1 = 24'($urandom); s2 = 24'($urandom); s3 = 24'($urandom);
      in_valid = 1'b1; set_ops(s1); step();
      set_ops(s2); step();
      #1 check_eq("t2_full", 32'(in_ready), 32'h0);
      set_ops(s3); step(); step();
      issue_en = 1'b1;
      step();
      check_eq("t2_i1", 32'(mul_issue), 32'h1);
      check_eq("t2_d1", 32'(unmask(dut_mul())), 32'(unmask(s1)));
      step();
      in_valid = 1'b0;
      check_eq("t2_i2", 32'(mul_issue), 32'h1);
      check_eq("t2_d2", 32'(unmask(dut_mul())), 32'(unmask(s2)));
      step();
      check_eq("t2_i3", 32'(mul_issue), 32'h1);
      check_eq("t2_d3", 32'(unmask(dut_mul())), 32'(unmask(s3)));
      issue_en = 1'b0;
      step(); step();

      // Zero seed falls back to the reset seed; zero shares expose r[3:0]
      seed_load = 1'b1; seed = 16'h0000; step();
      seed_load = 1'b0;
      set_ops(24'h0); in_valid = 1'b1; step();
      in_valid = 1'b0; issue_en = 1'b1; step();
      issue_en = 1'b0;
      check_eq("t3_a0", 32'(mul_a0), REFRESH ? 32'h1 : 32'h0);
      check_eq("t3_a1", 32'(mul_a1), REFRESH ? 32'h1 : 32'h0);

      // Idle: outputs hold
      snap = m_mul;
      for (int i = 0; i < 10; i++) step();
      check_eq("t5_hold", 32'(dut_mul()), 32'(snap));

      // Pass-through or refreshed shares of a=(3,5)
      lfsr_before = m_lfsr;
      r_lo = REFRESH ? lfsr_before[3:0] : 4'h0;
      set_ops(24'h35_12_34); in_valid = 1'b1; step();
      in_valid = 1'b0; issue_en = 1'b1; step();
      issue_en = 1'b0;
      check_eq("t6_a0", 32'(mul_a0), 32'(4'h3 ^ r_lo));
      check_eq("t6_a1", 32'(mul_a1), 32'(4'h5 ^ r_lo));
      step(); step();

      // Reset with two sets buffered and one in flight
      s1 = 24'($urandom); s2 = 24'($urandom); s3 = 24'($urandom);
      in_valid = 1'b1; set_ops(s1); step();
      set_ops(s2); step();
      issue_en = 1'b1; set_ops(s3); step();
      issue_en = 1'b0; step();
      check_eq("t4_pre_busy", 32'(busy), 32'h1);
      rst = 1'b1; in_valid = 1'b0; step();
      rst = 1'b0;
      #1 check_eq("t4_ready", 32'(in_ready), 32'h1);
      check_eq("t4_busy", 32'(busy), 32'h0);
      step();
      check_eq("t4_no_res", 32'(res_valid), 32'h0);
      step();

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         rst       = ($urandom_range(0, 149) == 0);
         in_valid  = $urandom_range(0, 1) == 1;
         issue_en  = $urandom_range(0, 2) != 0;
         seed_load = ($urandom_range(0, 29) == 0);
         seed      = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         set_ops(24'($urandom));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
